// File: rtl/fir_tapline.sv
// N-tap signed direct-form FIR with a valid-qualified sample path, a serially loaded
// double-buffered coefficient bank, saturating output and a 3-stage pipeline.
module fir_tapline #(
   parameter int TAP_SIZE    = 6,
   parameter int NBR_OF_TAPS = 3,
   parameter int X_N_SIZE    = 8,
   parameter int Y_N_SIZE    = 14
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic signed [X_N_SIZE-1:0] x_n,
   input  logic                       s_axis_fir_tvalid,
   input  logic                       s_set_coeffs,
   input  logic signed [TAP_SIZE-1:0] coef_in,
   input  logic                       coef_valid,
   input  logic                       clear,
   output logic signed [Y_N_SIZE-1:0] y_n,
   output logic                       m_axis_fir_tvalid,
   output logic                       sat,
   output logic                       coef_loaded,
   output logic                       busy_cfg
);

   localparam int PROD_W = TAP_SIZE + X_N_SIZE;
   localparam int ACC_W  = PROD_W + $clog2(NBR_OF_TAPS);
   localparam int EXT_W  = (ACC_W > Y_N_SIZE) ? ACC_W : Y_N_SIZE;
   localparam int CNT_W  = $clog2(NBR_OF_TAPS);

   localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(NBR_OF_TAPS - 1);
   localparam logic signed [EXT_W-1:0] Y_MAX    = {{(EXT_W-Y_N_SIZE+1){1'b0}}, {(Y_N_SIZE-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] Y_MIN    = {{(EXT_W-Y_N_SIZE+1){1'b1}}, {(Y_N_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, WAIT} cfg_state_t;

   cfg_state_t                 state;
   logic [CNT_W-1:0]           cnt;
   logic signed [TAP_SIZE-1:0] shadow [NBR_OF_TAPS];
   logic signed [TAP_SIZE-1:0] active [NBR_OF_TAPS];

   logic signed [X_N_SIZE-1:0] dly    [NBR_OF_TAPS];
   logic signed [PROD_W-1:0]   prod_c [NBR_OF_TAPS];
   logic signed [PROD_W-1:0]   prod   [NBR_OF_TAPS];
   logic                       v_dly;
   logic                       v_prod;

   logic signed [EXT_W-1:0]    acc;
   logic signed [Y_N_SIZE-1:0] y_c;
   logic                       sat_c;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         coef_loaded <= 1'b0;
         busy_cfg    <= 1'b0;
         for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         active[0] <= TAP_SIZE'(1);
      end else begin
         coef_loaded <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (s_set_coeffs) begin
                  state    <= LOAD;
                  busy_cfg <= 1'b1;
               end
            end
            LOAD: begin
               if (!s_set_coeffs) begin
                  state    <= IDLE;
                  busy_cfg <= 1'b0;
                  cnt      <= '0;
                  for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
                     shadow[i] <= '0;
                  end
               end else if (coef_valid) begin
                  shadow[cnt] <= coef_in;
                  cnt         <= cnt + 1'b1;
                  if (cnt == LAST_IDX) begin
                     state <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
                  active[i] <= shadow[i];
               end
               coef_loaded <= 1'b1;
               cnt         <= '0;
               state       <= WAIT;
            end
            WAIT: begin
               if (!s_set_coeffs) begin
                  state    <= IDLE;
                  busy_cfg <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               busy_cfg <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         v_dly <= 1'b0;
         for (int unsigned i = 0; i < NBR_OF_TAPS; i++) begin
            dly[i] <= '0;
         end
      end else begin
         v_dly <= s_axis_fir_tvalid;
         if (s_axis_fir_tvalid) begin
            dly[0] <= x_n;
            for (int unsigned i = 1; i < NBR_OF_TAPS; i++) begin
               dly[i] <= dly[i-1];
            end
         end
      end
   end

   // The whole bank is read at this stage only, so every output uses a single bank.
   always_comb begin
      for (int unsigned k = 0; k < NBR_OF_TAPS; k++) begin
         prod_c[k] = $signed({{X_N_SIZE{active[k][TAP_SIZE-1]}}, active[k]}) *
                     $signed({{TAP_SIZE{dly[k][X_N_SIZE-1]}}, dly[k]});
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v_prod <= 1'b0;
         for (int unsigned k = 0; k < NBR_OF_TAPS; k++) begin
            prod[k] <= '0;
         end
      end else begin
         v_prod <= v_dly & ~clear;
         for (int unsigned k = 0; k < NBR_OF_TAPS; k++) begin
            prod[k] <= prod_c[k];
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int unsigned k = 0; k < NBR_OF_TAPS; k++) begin
         acc = acc + {{(EXT_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
      end
      sat_c = 1'b0;
      y_c   = Y_N_SIZE'(acc);
      if (acc > Y_MAX) begin
         sat_c = 1'b1;
         y_c   = Y_N_SIZE'(Y_MAX);
      end else if (acc < Y_MIN) begin
         sat_c = 1'b1;
         y_c   = Y_N_SIZE'(Y_MIN);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         y_n               <= '0;
         sat               <= 1'b0;
         m_axis_fir_tvalid <= 1'b0;
      end else begin
         m_axis_fir_tvalid <= v_prod & ~clear;
         if (v_prod && !clear) begin
            y_n <= y_c;
            sat <= sat_c;
         end
      end
   end

endmodule

// File: tb/tb_fir_tapline.sv
// Directed, table-driven bench for fir_tapline with hand-computed expected outputs,
// plus hand-written sequences for coefficient loading, abort, reset and mid-stream commit.
module tb_fir_tapline;

   logic              clk = 1'b0;
   logic              reset_n;
   logic signed [7:0] x_n;
   logic              s_axis_fir_tvalid;
   logic              s_set_coeffs;
   logic signed [5:0] coef_in;
   logic              coef_valid;
   logic              clear;
   logic signed [13:0] y_n;
   logic              m_axis_fir_tvalid;
   logic              sat;
   logic              coef_loaded;
   logic              busy_cfg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fir_tapline #(
      .TAP_SIZE(6),
      .NBR_OF_TAPS(3),
      .X_N_SIZE(8),
      .Y_N_SIZE(14)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .x_n(x_n),
      .s_axis_fir_tvalid(s_axis_fir_tvalid),
      .s_set_coeffs(s_set_coeffs),
      .coef_in(coef_in),
      .coef_valid(coef_valid),
      .clear(clear),
      .y_n(y_n),
      .m_axis_fir_tvalid(m_axis_fir_tvalid),
      .sat(sat),
      .coef_loaded(coef_loaded),
      .busy_cfg(busy_cfg)
   );

   typedef struct {
      int   seg;
      int   x;
      logic v;
      logic c;
      logic ev;
      int   ey;
      logic es;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(int seg, int x, logic v, logic c, logic ev, int ey, logic es);
      vec_t r;
      r.seg = seg; r.x = x; r.v = v; r.c = c; r.ev = ev; r.ey = ey; r.es = es;
      vecs.push_back(r);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int x, input logic v, input logic c,
                      input logic ev, input int ey, input logic es);
      x_n = x[7:0];
      s_axis_fir_tvalid = v;
      clear = c;
      @(posedge clk);
      #1;
      chk("tvalid", int'(m_axis_fir_tvalid), int'(ev));
      if (ev) begin
         chk("y", int'(y_n), ey);
         chk("sat", int'(sat), int'(es));
      end
      x_n = '0;
      s_axis_fir_tvalid = 1'b0;
      clear = 1'b0;
   endtask

   task automatic run_seg(input int seg);
      foreach (vecs[i]) begin
         if (vecs[i].seg == seg) begin
            cyc(vecs[i].x, vecs[i].v, vecs[i].c, vecs[i].ev, vecs[i].ey, vecs[i].es);
         end
      end
   endtask

   task automatic load3(input int c0, input int c1, input int c2, input logic junk);
      int c[3];
      c = '{c0, c1, c2};
      s_set_coeffs = 1'b1;
      coef_valid = junk;
      coef_in = 6'sd31;
      cyc(0, 0, 0, 0, 0, 0);
      chk("busy_load", busy_cfg, 1);
      for (int i = 0; i < 3; i++) begin
         coef_valid = 1'b1;
         coef_in = c[i][5:0];
         cyc(0, 0, 0, 0, 0, 0);
         chk("coef_loaded_early", coef_loaded, 0);
      end
      coef_valid = 1'b0;
      cyc(0, 0, 0, 0, 0, 0);
      chk("coef_loaded_pulse", coef_loaded, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("coef_loaded_end", coef_loaded, 0);
      chk("busy_wait", busy_cfg, 1);
      s_set_coeffs = 1'b0;
      cyc(0, 0, 0, 0, 0, 0);
      chk("busy_idle", busy_cfg, 0);
   endtask

   initial begin
      // seg 1: passthrough with the reset (impulse) bank
      add(1,   5, 1, 0, 0,   0, 0);
      add(1,  -3, 1, 0, 0,   0, 0);
      add(1, 127, 1, 0, 1,   5, 0);
      add(1,   0, 0, 0, 1,  -3, 0);
      add(1,   0, 0, 0, 1, 127, 0);
      add(1,   0, 0, 0, 0,   0, 0);
      // seg 2: bank [1,2,1], impulse 10
      add(2,  0, 0, 1, 0,  0, 0);
      add(2, 10, 1, 0, 0,  0, 0);
      add(2,  0, 1, 0, 0,  0, 0);
      add(2,  0, 1, 0, 1, 10, 0);
      add(2,  0, 1, 0, 1, 20, 0);
      add(2,  0, 0, 0, 1, 10, 0);
      add(2,  0, 0, 0, 1,  0, 0);
      add(2,  0, 0, 0, 0,  0, 0);
      // seg 3: bank [1,2,1], clear with valid drops sample and history
      add(3, 10, 1, 0, 0,  0, 0);
      add(3, 20, 1, 0, 0,  0, 0);
      add(3, 30, 1, 0, 1, 10, 0);
      add(3, 99, 1, 1, 0,  0, 0);
      add(3,  1, 1, 0, 0,  0, 0);
      add(3,  0, 1, 0, 0,  0, 0);
      add(3,  0, 1, 0, 1,  1, 0);
      add(3,  0, 0, 0, 1,  2, 0);
      add(3,  0, 0, 0, 1,  1, 0);
      add(3,  0, 0, 0, 0,  0, 0);
      // seg 4: bank [-32,-32,-32], positive saturation
      add(4,    0, 0, 1, 0,    0, 0);
      add(4, -128, 1, 0, 0,    0, 0);
      add(4, -128, 1, 0, 0,    0, 0);
      add(4, -128, 1, 0, 1, 4096, 0);
      add(4,    0, 0, 0, 1, 8191, 1);
      add(4,    0, 0, 0, 1, 8191, 1);
      add(4,    0, 0, 0, 0,    0, 0);
      // seg 5: bank [31,31,31], negative saturation
      add(5,    0, 0, 1, 0,     0, 0);
      add(5, -128, 1, 0, 0,     0, 0);
      add(5, -128, 1, 0, 0,     0, 0);
      add(5, -128, 1, 0, 1, -3968, 0);
      add(5,    0, 0, 0, 1, -7936, 0);
      add(5,    0, 0, 0, 1, -8192, 1);
      add(5,    0, 0, 0, 0,     0, 0);
      // seg 6: impulse 9 after reset mid-load
      add(6, 9, 1, 0, 0, 0, 0);
      add(6, 0, 1, 0, 0, 0, 0);
      add(6, 0, 1, 0, 1, 9, 0);
      add(6, 0, 0, 0, 1, 0, 0);
      add(6, 0, 0, 0, 1, 0, 0);
      add(6, 0, 0, 0, 0, 0, 0);
      // seg 7: impulse 7 after aborted load
      add(7, 0, 0, 1, 0, 0, 0);
      add(7, 7, 1, 0, 0, 0, 0);
      add(7, 0, 1, 0, 0, 0, 0);
      add(7, 0, 1, 0, 1, 7, 0);
      add(7, 0, 0, 0, 1, 0, 0);
      add(7, 0, 0, 0, 1, 0, 0);
      add(7, 0, 0, 0, 0, 0, 0);

      reset_n = 1'b0;
      x_n = '0;
      s_axis_fir_tvalid = 1'b0;
      s_set_coeffs = 1'b0;
      coef_in = '0;
      coef_valid = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_y", int'(y_n), 0);
      chk("rst_tvalid", m_axis_fir_tvalid, 0);
      chk("rst_sat", sat, 0);
      chk("rst_coef_loaded", coef_loaded, 0);
      chk("rst_busy", busy_cfg, 0);
      reset_n = 1'b1;

      run_seg(1);
      load3(1, 2, 1, 1'b1);
      run_seg(2);
      run_seg(3);
      load3(-32, -32, -32, 1'b0);
      run_seg(4);
      load3(31, 31, 31, 1'b0);
      run_seg(5);

      // reset in the middle of a load
      s_set_coeffs = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      coef_valid = 1'b1;
      coef_in = 6'sd5;
      cyc(0, 0, 0, 0, 0, 0);
      chk("busy_midload", busy_cfg, 1);
      reset_n = 1'b0;
      s_set_coeffs = 1'b0;
      coef_valid = 1'b0;
      cyc(0, 0, 0, 0, 0, 0);
      chk("busy_after_reset", busy_cfg, 0);
      chk("y_after_reset", int'(y_n), 0);
      chk("sat_after_reset", sat, 0);
      reset_n = 1'b1;
      run_seg(6);

      // abort after two of three coefficients
      s_set_coeffs = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      coef_valid = 1'b1;
      coef_in = 6'sd3;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("busy_abort_load", busy_cfg, 1);
      s_set_coeffs = 1'b0;
      coef_valid = 1'b0;
      cyc(0, 0, 0, 0, 0, 0);
      chk("busy_abort", busy_cfg, 0);
      chk("coef_loaded_abort", coef_loaded, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("coef_loaded_abort2", coef_loaded, 0);
      run_seg(7);

      // commit of [0,1,2] over the impulse bank during a continuous ramp
      cyc(0, 0, 1, 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         int   j;
         int   ey;
         logic ev;
         s_set_coeffs = (k <= 8);
         coef_valid = (k >= 2 && k <= 4);
         coef_in = 6'(k - 2);
         j = k - 2;
         ev = (j >= 1 && j <= 8);
         ey = (j <= 4) ? j : 3 * j - 5;
         cyc((k <= 8) ? k : 0, (k <= 8), 1'b0, ev, ey, 1'b0);
         chk("commit_pulse", coef_loaded, int'(k == 5));
         chk("commit_busy", busy_cfg, int'(k <= 8));
      end
      coef_valid = 1'b0;
      s_set_coeffs = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
